// File: rtl/pixel_timing_gen.sv
// Raster timing generator: pixel clock-enable divider, h/v counters, syncs, DE,
// frame counter and scroll-adjusted coordinates with commit at vblank entry.
`timescale 1ns/1ps
module pixel_timing_gen #(
    parameter int PIX_DIV   = 5,
    parameter int HRES      = 640,
    parameter int HFP       = 16,
    parameter int HSW       = 96,
    parameter int HBP       = 48,
    parameter int VRES      = 480,
    parameter int VFP       = 10,
    parameter int VSW       = 2,
    parameter int VBP       = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int HSZ       = 10,
    parameter int VSZ       = 10
) (
    input  logic           clk_125mhz,
    input  logic           rstn_i,
    output logic           pix_ce_o,
    output logic [HSZ-1:0] hcount_o,
    output logic [VSZ-1:0] vcount_o,
    output logic           de_o,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic [HSZ-1:0] xpix_o,
    output logic [VSZ-1:0] ypix_o,
    output logic [5:0]     frame_o,
    output logic           vblank_start_o,
    input  logic           cmd_valid_i,
    output logic           cmd_ready_o,
    input  logic [1:0]     cmd_addr_i,
    input  logic [15:0]    cmd_data_i
);
    localparam int HTOTAL = HRES + HFP + HSW + HBP;
    localparam int VTOTAL = VRES + VFP + VSW + VBP;
    localparam int DIVW   = $clog2(PIX_DIV);

    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(PIX_DIV - 1);
    localparam logic [HSZ-1:0]  H_LAST   = HSZ'(HTOTAL - 1);
    localparam logic [HSZ-1:0]  H_ACT    = HSZ'(HRES);
    localparam logic [HSZ-1:0]  H_MAX    = HSZ'(HRES - 1);
    localparam logic [HSZ-1:0]  HS_BEG   = HSZ'(HRES + HFP);
    localparam logic [HSZ-1:0]  HS_END   = HSZ'(HRES + HFP + HSW);
    localparam logic [VSZ-1:0]  V_LAST   = VSZ'(VTOTAL - 1);
    localparam logic [VSZ-1:0]  V_ACT    = VSZ'(VRES);
    localparam logic [VSZ-1:0]  V_MAX    = VSZ'(VRES - 1);
    localparam logic [VSZ-1:0]  VS_BEG   = VSZ'(VRES + VFP);
    localparam logic [VSZ-1:0]  VS_END   = VSZ'(VRES + VFP + VSW);

    logic [DIVW-1:0] div_q, div_d;
    logic            en_q, en_d;
    logic            run_q, run_d;
    logic [HSZ-1:0]  h_q, h_d, sx_sh_q, sx_sh_d, sx_q, sx_d, xpix_q, xpix_d;
    logic [VSZ-1:0]  v_q, v_d, sy_sh_q, sy_sh_d, sy_q, sy_d, ypix_q, ypix_d;
    logic [5:0]      frame_q, frame_d;
    logic            de_q, de_d, hs_q, hs_d, vs_q, vs_d, vbs_q, vbs_d;
    logic            ce, commit, accept;
    logic [HSZ:0]    xsum, xwrap;
    logic [VSZ:0]    ysum, ywrap;

    always_comb begin
        ce    = (div_q == DIV_LAST);
        div_d = ce ? '0 : div_q + 1'b1;

        // run_q separates "held at 0 while idle" from "showing pixel (0,0)"
        run_d = run_q;
        h_d   = h_q;
        v_d   = v_q;
        if (ce) begin
            if (!en_q || !run_q) begin
                run_d = en_q;
                h_d   = '0;
                v_d   = '0;
            end else if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end

        commit = ce && en_q && run_q && (h_d == '0) && (v_d == V_ACT);
        accept = cmd_valid_i && !commit;

        en_d    = en_q;
        sx_sh_d = sx_sh_q;
        sy_sh_d = sy_sh_q;
        sx_d    = commit ? sx_sh_q : sx_q;
        sy_d    = commit ? sy_sh_q : sy_q;
        frame_d = commit ? frame_q + 6'd1 : frame_q;
        if (accept) begin
            case (cmd_addr_i)
                2'd0: sx_sh_d = (cmd_data_i >= 16'(HRES)) ? H_MAX : cmd_data_i[HSZ-1:0];
                2'd1: sy_sh_d = (cmd_data_i >= 16'(VRES)) ? V_MAX : cmd_data_i[VSZ-1:0];
                2'd2: en_d    = cmd_data_i[0];
                default: frame_d = '0;
            endcase
        end

        de_d  = run_d && (h_d < H_ACT) && (v_d < V_ACT);
        hs_d  = (run_d && (h_d >= HS_BEG) && (h_d < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vs_d  = (run_d && (v_d >= VS_BEG) && (v_d < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        vbs_d = commit;

        // Both operands are below the active size, so one subtraction wraps
        xsum   = {1'b0, h_d} + {1'b0, sx_q};
        xwrap  = xsum - {1'b0, H_ACT};
        ysum   = {1'b0, v_d} + {1'b0, sy_q};
        ywrap  = ysum - {1'b0, V_ACT};
        xpix_d = !de_d ? '0 : (xsum >= {1'b0, H_ACT}) ? xwrap[HSZ-1:0] : xsum[HSZ-1:0];
        ypix_d = !de_d ? '0 : (ysum >= {1'b0, V_ACT}) ? ywrap[VSZ-1:0] : ysum[VSZ-1:0];
    end

    always_ff @(posedge clk_125mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            div_q   <= '0;
            en_q    <= 1'b0;
            run_q   <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            sx_sh_q <= '0;
            sy_sh_q <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            frame_q <= '0;
            de_q    <= 1'b0;
            hs_q    <= ~HSYNC_POL;
            vs_q    <= ~VSYNC_POL;
            vbs_q   <= 1'b0;
            xpix_q  <= '0;
            ypix_q  <= '0;
        end else begin
            div_q   <= div_d;
            en_q    <= en_d;
            run_q   <= run_d;
            h_q     <= h_d;
            v_q     <= v_d;
            sx_sh_q <= sx_sh_d;
            sy_sh_q <= sy_sh_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            frame_q <= frame_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            vbs_q   <= vbs_d;
            xpix_q  <= xpix_d;
            ypix_q  <= ypix_d;
        end
    end

    assign pix_ce_o       = ce;
    assign cmd_ready_o    = !commit;
    assign hcount_o       = h_q;
    assign vcount_o       = v_q;
    assign de_o           = de_q;
    assign hsync_o        = hs_q;
    assign vsync_o        = vs_q;
    assign xpix_o         = xpix_q;
    assign ypix_o         = ypix_q;
    assign frame_o        = frame_q;
    assign vblank_start_o = vbs_q;
endmodule

// File: tb/tb_pixel_timing_gen.sv
// Bench for pixel_timing_gen: small-raster instance against a frame-position model,
// plus default-size and PIX_DIV=4/inverted-polarity instances for line-level checks.
`timescale 1ns/1ps
module tb_pixel_timing_gen;
    localparam int PD = 2, HR = 16, HFP = 2, HSW = 3, HBP = 3;
    localparam int VR = 8, VFP = 1, VSW = 2, VBP = 1;
    localparam int HT = HR + HFP + HSW + HBP;
    localparam int VT = VR + VFP + VSW + VBP;
    localparam int FRAME = HT * VT * PD;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic        rstn, rstn_x;
    logic        cmd_valid, x_valid;
    logic [1:0]  cmd_addr, x_addr;
    logic [15:0] cmd_data, x_data;

    logic a_ce, a_de, a_hs, a_vs, a_vbs, a_ready;
    logic [4:0] a_h, a_x;
    logic [3:0] a_v, a_y;
    logic [5:0] a_frame;

    logic d_ce, d_de, d_hs, d_vs, d_vbs, d_ready;
    logic [9:0] d_h, d_v, d_x, d_y;
    logic [5:0] d_frame;

    logic b_ce, b_de, b_hs, b_vs, b_vbs, b_ready;
    logic [4:0] b_h, b_x;
    logic [3:0] b_v, b_y;
    logic [5:0] b_frame;

    pixel_timing_gen #(.PIX_DIV(PD), .HRES(HR), .HFP(HFP), .HSW(HSW), .HBP(HBP),
        .VRES(VR), .VFP(VFP), .VSW(VSW), .VBP(VBP), .HSZ(5), .VSZ(4)) dut (
        .clk_125mhz(clk), .rstn_i(rstn), .pix_ce_o(a_ce), .hcount_o(a_h), .vcount_o(a_v),
        .de_o(a_de), .hsync_o(a_hs), .vsync_o(a_vs), .xpix_o(a_x), .ypix_o(a_y),
        .frame_o(a_frame), .vblank_start_o(a_vbs), .cmd_valid_i(cmd_valid),
        .cmd_ready_o(a_ready), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data));

    pixel_timing_gen dut_d (
        .clk_125mhz(clk), .rstn_i(rstn_x), .pix_ce_o(d_ce), .hcount_o(d_h), .vcount_o(d_v),
        .de_o(d_de), .hsync_o(d_hs), .vsync_o(d_vs), .xpix_o(d_x), .ypix_o(d_y),
        .frame_o(d_frame), .vblank_start_o(d_vbs), .cmd_valid_i(x_valid),
        .cmd_ready_o(d_ready), .cmd_addr_i(x_addr), .cmd_data_i(x_data));

    pixel_timing_gen #(.PIX_DIV(4), .HRES(HR), .HFP(HFP), .HSW(HSW), .HBP(HBP),
        .VRES(VR), .VFP(VFP), .VSW(VSW), .VBP(VBP), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .HSZ(5), .VSZ(4)) dut_b (
        .clk_125mhz(clk), .rstn_i(rstn_x), .pix_ce_o(b_ce), .hcount_o(b_h), .vcount_o(b_v),
        .de_o(b_de), .hsync_o(b_hs), .vsync_o(b_vs), .xpix_o(b_x), .ypix_o(b_y),
        .frame_o(b_frame), .vblank_start_o(b_vbs), .cmd_valid_i(x_valid),
        .cmd_ready_o(b_ready), .cmd_addr_i(x_addr), .cmd_data_i(x_data));

    // Reference model: a single linear pixel position inside the frame
    int m_cyc, m_pos, m_sx_sh, m_sy_sh, m_sx, m_sy, m_frame;
    bit m_en, m_run, m_vbs, m_acc;
    int n_checks = 0, n_errors = 0;

    typedef struct { int sx; int sy; int ph; int pv; int ex; int ey; } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ce();
        return (m_cyc % PD) == PD - 1;
    endfunction

    function automatic bit exp_ready();
        return !(exp_ce() && m_en && m_run && m_pos == VR * HT - 1);
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_pos = 0; m_sx_sh = 0; m_sy_sh = 0; m_sx = 0; m_sy = 0;
        m_frame = 0; m_en = 0; m_run = 0; m_vbs = 0; m_acc = 0;
    endtask

    task automatic model_step();
        bit ce, acc, commit;
        if (!rstn) begin
            model_reset();
            return;
        end
        ce = exp_ce();
        acc = cmd_valid && exp_ready();
        commit = 0;
        if (ce) begin
            if (!m_en) begin
                m_run = 0; m_pos = 0;
            end else if (!m_run) begin
                m_run = 1; m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % (HT * VT);
                commit = (m_pos == VR * HT);
            end
        end
        m_vbs = commit;
        if (commit) begin
            m_sx = m_sx_sh; m_sy = m_sy_sh; m_frame = (m_frame + 1) % 64;
        end
        if (acc) begin
            case (cmd_addr)
                2'd0: m_sx_sh = (int'(cmd_data) >= HR) ? HR - 1 : int'(cmd_data);
                2'd1: m_sy_sh = (int'(cmd_data) >= VR) ? VR - 1 : int'(cmd_data);
                2'd2: m_en = cmd_data[0];
                default: m_frame = 0;
            endcase
        end
        m_acc = acc;
        m_cyc++;
    endtask

    task automatic check_all();
        int h, v;
        bit de, hsa, vsa;
        h = m_run ? m_pos % HT : 0;
        v = m_run ? m_pos / HT : 0;
        de = m_run && h < HR && v < VR;
        hsa = m_run && h >= HR + HFP && h < HR + HFP + HSW;
        vsa = m_run && v >= VR + VFP && v < VR + VFP + VSW;
        chk("pix_ce", 32'(a_ce), 32'(exp_ce()));
        chk("hcount", 32'(a_h), h);
        chk("vcount", 32'(a_v), v);
        chk("de", 32'(a_de), 32'(de));
        chk("hsync", 32'(a_hs), 32'(!hsa));
        chk("vsync", 32'(a_vs), 32'(!vsa));
        chk("xpix", 32'(a_x), de ? (h + m_sx) % HR : 0);
        chk("ypix", 32'(a_y), de ? (v + m_sy) % VR : 0);
        chk("frame", 32'(a_frame), m_frame);
        chk("vblank_start", 32'(a_vbs), 32'(m_vbs));
        chk("cmd_ready", 32'(a_ready), 32'(exp_ready()));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic cmd_write(input logic [1:0] a, input logic [15:0] d);
        bit acc;
        acc = 0;
        cmd_valid = 1; cmd_addr = a; cmd_data = d;
        for (int i = 0; i < 8 && !acc; i++) begin
            tick();
            acc = m_acc;
        end
        cmd_valid = 0;
        chk("cmd_accept_timeout", 32'(acc), 1);
    endtask

    task automatic wait_pos(input int h, input int v);
        int n;
        n = 0;
        while (!(int'(a_h) == h && int'(a_v) == v) && n < 3 * FRAME) begin
            tick(); n++;
        end
        chk("wait_pos_timeout", 32'(n < 3 * FRAME), 1);
    endtask

    task automatic wait_vbs();
        int n;
        n = 0;
        do begin
            tick(); n++;
        end while (!a_vbs && n < 2 * FRAME);
        chk("wait_vbs_timeout", 32'(a_vbs), 1);
    endtask

    task automatic probe(input int ph, input int pv, input int ex, input int ey);
        int n;
        n = 0;
        while (!(int'(a_h) == ph && int'(a_v) == pv && a_de) && n < 3 * FRAME) begin
            tick(); n++;
        end
        chk("probe_timeout", 32'(n < 3 * FRAME), 1);
        chk("probe_xpix", 32'(a_x), ex);
        chk("probe_ypix", 32'(a_y), ey);
    endtask

    initial begin
        int n, lowcnt, minh, maxh, decnt, vsbad, last_d, per_d, bad_d, last_b, per_b, bad_b;
        int bminh, bmaxh, bminv, bmaxv, bcnt;
        bit done;

        tbl[0] = '{5, 0, 0, 0, 5, 0};
        tbl[1] = '{5, 0, 10, 2, 15, 2};
        tbl[2] = '{5, 3, 11, 5, 0, 0};
        tbl[3] = '{100, 700, 1, 1, 0, 0};
        tbl[4] = '{15, 7, 0, 0, 15, 7};
        tbl[5] = '{0, 1, 15, 7, 15, 0};
        tbl[6] = '{16, 8, 0, 0, 15, 7};

        rstn = 0; rstn_x = 0;
        cmd_valid = 0; cmd_addr = 0; cmd_data = 0;
        x_valid = 0; x_addr = 0; x_data = 0;
        model_reset();
        repeat (3) tick();
        chk("rst_hsync", 32'(a_hs), 1);
        chk("rst_ready", 32'(a_ready), 1);
        rstn = 1;
        repeat (6) tick();
        chk("idle_de", 32'(a_de), 0);

        // Enable, then scroll vectors: write mid-frame, expect effect after commit
        cmd_write(2'd2, 16'd1);
        for (int i = 0; i < 7; i++) begin
            wait_pos(0, 3);
            cmd_write(2'd0, 16'(tbl[i].sx));
            cmd_write(2'd1, 16'(tbl[i].sy));
            wait_vbs();
            probe(tbl[i].ph, tbl[i].pv, tbl[i].ex, tbl[i].ey);
        end

        wait_vbs();
        n = 0;
        do begin
            tick(); n++;
        end while (!a_vbs && n < 2 * FRAME);
        chk("frame_length", n, FRAME);

        // Command held across the commit edge
        n = 0;
        while (!(int'(a_h) == HT - 1 && int'(a_v) == VR - 1 && a_ce) && n < 2 * FRAME) begin
            tick(); n++;
        end
        chk("commit_cycle_timeout", 32'(n < 2 * FRAME), 1);
        chk("ready_in_commit", 32'(a_ready), 0);
        cmd_valid = 1; cmd_addr = 2'd0; cmd_data = 16'd9;
        tick();
        chk("vbs_after_commit", 32'(a_vbs), 1);
        chk("ready_after_commit", 32'(a_ready), 1);
        tick();
        cmd_valid = 0;
        probe(0, 0, 15, 7);
        wait_vbs();
        probe(0, 0, 9, 7);

        wait_pos(0, 3);
        cmd_write(2'd0, 16'd3);
        cmd_write(2'd0, 16'd11);
        wait_vbs();
        probe(0, 0, 11, 7);

        // Frame clear, then a full 64-frame wrap
        chk("frame_nonzero", 32'(a_frame != 0), 1);
        wait_pos(2, 4);
        cmd_write(2'd3, 16'd0);
        chk("frame_cleared", 32'(a_frame), 0);
        n = 0;
        while (a_frame != 6'd63 && n < 70) begin
            wait_vbs(); n++;
        end
        chk("frame_reach_63", 32'(a_frame), 63);
        wait_vbs();
        chk("frame_wrap", 32'(a_frame), 0);

        // Disable mid-frame, re-enable
        wait_pos(3, 5);
        cmd_write(2'd2, 16'd0);
        repeat (PD) tick();
        chk("dis_h", 32'(a_h), 0);
        chk("dis_v", 32'(a_v), 0);
        chk("dis_de", 32'(a_de), 0);
        chk("dis_hsync", 32'(a_hs), 1);
        chk("dis_vsync", 32'(a_vs), 1);
        cmd_write(2'd2, 16'd1);
        n = 0;
        while (!a_de && n < 2 * PD) begin
            tick(); n++;
        end
        chk("reen_de", 32'(a_de), 1);
        chk("reen_h", 32'(a_h), 0);
        chk("reen_v", 32'(a_v), 0);

        // Asynchronous reset mid-line
        wait_pos(7, 2);
        rstn = 0;
        #1;
        chk("arst_h", 32'(a_h), 0);
        chk("arst_v", 32'(a_v), 0);
        chk("arst_de", 32'(a_de), 0);
        chk("arst_hsync", 32'(a_hs), 1);
        chk("arst_ce", 32'(a_ce), 0);
        chk("arst_ready", 32'(a_ready), 1);
        chk("arst_frame", 32'(a_frame), 0);
        model_reset();
        repeat (3) tick();
        rstn = 1;
        cmd_write(2'd2, 16'd1);

        // Randomized command traffic against the model
        for (int i = 0; i < 6000; i++) begin
            if (!cmd_valid && $urandom_range(0, 9) == 0) begin
                cmd_valid = 1;
                cmd_addr = 2'($urandom_range(0, 3));
                case (cmd_addr)
                    2'd2: cmd_data = {15'($urandom), 1'($urandom_range(0, 9) != 0)};
                    2'd3: cmd_data = 16'($urandom);
                    default: cmd_data = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                                    : 16'($urandom_range(0, 20));
                endcase
            end
            tick();
            if (m_acc) cmd_valid = 0;
        end
        cmd_valid = 0;

        // Default-size and PIX_DIV=4/inverted-polarity instances
        chk("d_rst_ce", 32'(d_ce), 0);
        chk("d_rst_hsync", 32'(d_hs), 1);
        chk("d_rst_vsync", 32'(d_vs), 1);
        chk("d_rst_de", 32'(d_de), 0);
        chk("d_rst_frame", 32'(d_frame), 0);
        chk("b_rst_hsync", 32'(b_hs), 0);
        chk("b_rst_vsync", 32'(b_vs), 0);
        rstn_x = 1;
        tick();
        chk("d_ready_idle", 32'(d_ready), 1);
        chk("b_ready_idle", 32'(b_ready), 1);
        x_valid = 1; x_addr = 2'd2; x_data = 16'd1;
        tick();
        x_valid = 0;
        lowcnt = 0; minh = 9999; maxh = -1; decnt = 0; vsbad = 0;
        last_d = -1; per_d = 0; bad_d = 0; last_b = -1; per_b = 0; bad_b = 0;
        bminh = 99; bmaxh = -1; bminv = 99; bmaxv = -1; bcnt = 0; done = 0;
        for (int c = 0; c < 5000 && !done; c++) begin
            tick();
            if (int'(d_v) != 0) begin
                done = 1;
            end else begin
                if (d_ce) begin
                    if (last_d >= 0) begin
                        if (per_d == 0) per_d = c - last_d;
                        else if (c - last_d != per_d) bad_d++;
                    end
                    last_d = c;
                end
                if (b_ce) begin
                    if (last_b >= 0) begin
                        if (per_b == 0) per_b = c - last_b;
                        else if (c - last_b != per_b) bad_b++;
                    end
                    last_b = c;
                end
                if (!d_hs) begin
                    lowcnt++;
                    if (int'(d_h) < minh) minh = int'(d_h);
                    if (int'(d_h) > maxh) maxh = int'(d_h);
                end
                if (d_de) decnt++;
                if (d_vs !== 1'b1) vsbad++;
                if (b_hs) begin
                    if (int'(b_h) < bminh) bminh = int'(b_h);
                    if (int'(b_h) > bmaxh) bmaxh = int'(b_h);
                    if (b_v == 4'd0 && b_frame == 6'd0) bcnt++;
                end
                if (b_vs) begin
                    if (int'(b_v) < bminv) bminv = int'(b_v);
                    if (int'(b_v) > bmaxv) bmaxv = int'(b_v);
                end
            end
        end
        chk("d_line_done", 32'(done), 1);
        chk("d_ce_period", per_d, 5);
        chk("d_ce_irregular", bad_d, 0);
        chk("d_hsync_low_cycles", lowcnt, 96 * 5);
        chk("d_hsync_first_h", minh, 656);
        chk("d_hsync_last_h", maxh, 751);
        chk("d_de_cycles", decnt, 640 * 5);
        chk("d_vsync_line0", vsbad, 0);
        chk("b_ce_period", per_b, 4);
        chk("b_ce_irregular", bad_b, 0);
        chk("b_hsync_first_h", bminh, HR + HFP);
        chk("b_hsync_last_h", bmaxh, HR + HFP + HSW - 1);
        chk("b_hsync_line0_cycles", bcnt, HSW * 4);
        chk("b_vsync_first_v", bminv, VR + VFP);
        chk("b_vsync_last_v", bmaxv, VR + VFP + VSW - 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
